// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the NTT twiddle sequencer.
// Defaults describe a 32-point transform over q = 65537.
package ntt_pkg;

    localparam int N       = 32;
    localparam int LOGN    = 5;
    localparam int Q       = 65537;
    localparam int Q_WIDTH = 17;
    localparam int ADDR_W  = 7;
    localparam int IDX_W   = LOGN;
    localparam int J_W     = LOGN - 1;
    localparam int S_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/ntt_index_gen.sv
// Maps (stage, butterfly) to Cooley-Tukey operand indices and the ROM address.
// Because t is a power of two, the divide and modulo reduce to masking.
module ntt_index_gen
    import ntt_pkg::*;
(
    input  logic [S_W-1:0]    i_s,
    input  logic [J_W-1:0]    i_j,
    output logic [IDX_W-1:0]  o_idx_a,
    output logic [IDX_W-1:0]  o_idx_b,
    output logic [ADDR_W-1:0] o_psi_addr,
    output logic              o_last
);

    logic [IDX_W-1:0] w_t;
    logic [IDX_W-1:0] w_mask;
    logic [IDX_W-1:0] w_j;
    logic [IDX_W-1:0] w_a;

    assign w_t    = IDX_W'(N / 2) >> i_s;
    assign w_mask = w_t - IDX_W'(1);
    assign w_j    = IDX_W'(i_j);

    // The group bits of j move up one place (2*g*t); the offset k stays put.
    assign w_a     = ((w_j & ~w_mask) << 1) | (w_j & w_mask);
    assign o_idx_a = w_a;
    assign o_idx_b = w_a | w_t;

    assign o_psi_addr = ADDR_W'(i_s) * ADDR_W'(N / 2) + ADDR_W'(i_j);
    assign o_last     = (i_s == S_W'(LOGN - 1)) && (i_j == J_W'(N / 2 - 1));

endmodule

// File: rtl/ntt_twiddle_sequencer.sv
// Walks every butterfly of a forward NTT, fetches its twiddle from an external
// combinational ROM and streams {twiddle, indices, stage} over valid/ready.
module ntt_twiddle_sequencer
    import ntt_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  psi_addr,
    input  logic [Q_WIDTH-1:0] psi_value,
    output logic               tw_valid,
    input  logic               tw_ready,
    output logic [Q_WIDTH-1:0] tw_value,
    output logic [IDX_W-1:0]   tw_idx_a,
    output logic [IDX_W-1:0]   tw_idx_b,
    output logic [2:0]         tw_stage,
    output logic               tw_last,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    state_t             w_nextState;
    logic [S_W-1:0]     r_s;
    logic [J_W-1:0]     r_j;
    logic               r_valid;
    logic [Q_WIDTH-1:0] r_value;
    logic [IDX_W-1:0]   r_idxA;
    logic [IDX_W-1:0]   r_idxB;
    logic [S_W-1:0]     r_stage;
    logic               r_last;
    logic               r_done;

    logic [IDX_W-1:0]   w_idxA;
    logic [IDX_W-1:0]   w_idxB;
    logic               w_last;
    logic               w_load;
    logic               w_clear;
    logic               w_finish;

    ntt_index_gen u_index_gen (
        .i_s        (r_s),
        .i_j        (r_j),
        .o_idx_a    (w_idxA),
        .o_idx_b    (w_idxB),
        .o_psi_addr (psi_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort outranks both loading and consumption; a start landing on the
    // done cycle is dropped so every run needs a fresh request from IDLE.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_nextState = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_nextState = IDLE;
                    w_clear     = 1'b1;
                end else if (!r_valid || tw_ready) begin
                    w_load = 1'b1;
                    if (w_last) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_nextState = IDLE;
                    w_clear     = 1'b1;
                end else if (r_valid && tw_ready) begin
                    w_nextState = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_j     <= '0;
            r_valid <= 1'b0;
            r_value <= '0;
            r_idxA  <= '0;
            r_idxB  <= '0;
            r_stage <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_clear) begin
                r_s     <= '0;
                r_j     <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_value <= psi_value;
                r_idxA  <= w_idxA;
                r_idxB  <= w_idxB;
                r_stage <= r_s;
                r_last  <= w_last;
                // Counters park at zero once the final butterfly is captured.
                if (r_j == J_W'(N / 2 - 1)) begin
                    r_j <= '0;
                    r_s <= w_last ? '0 : r_s + S_W'(1);
                end else begin
                    r_j <= r_j + J_W'(1);
                end
            end else if (w_finish) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign tw_valid = r_valid;
    assign tw_value = r_value;
    assign tw_idx_a = r_idxA;
    assign tw_idx_b = r_idxB;
    assign tw_stage = r_stage;
    assign tw_last  = r_last;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Scoreboard bench for ntt_twiddle_sequencer: stimulus queues the expected
// butterfly schedule, a negedge monitor pops and compares every transfer.
module tb_ntt_twiddle_sequencer;
    import ntt_pkg::*;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               tw_ready = 1'b1;
    logic [ADDR_W-1:0]  psi_addr;
    logic [Q_WIDTH-1:0] psi_value;
    logic               tw_valid;
    logic [Q_WIDTH-1:0] tw_value;
    logic [IDX_W-1:0]   tw_idx_a;
    logic [IDX_W-1:0]   tw_idx_b;
    logic [2:0]         tw_stage;
    logic               tw_last;
    logic               busy;
    logic               done;

    typedef struct {
        int a;
        int b;
        int stage;
        int last;
        int value;
    } entry_t;

    entry_t expQ[$];
    entry_t monEntry;
    int     nTests      = 0;
    int     nFail       = 0;
    int     doneSeen    = 0;
    int     runXfer     = 0;
    bit     pendingDone = 1'b0;
    bit     randReady   = 1'b0;

    always #5 clk = ~clk;

    // Test-pattern ROM: 2^(addr/2) mod q plus the address LSB, so addr 24 -> 4096.
    function automatic logic [Q_WIDTH-1:0] romFn(input int addr);
        int p;
        p = 1;
        for (int i = 0; i < addr / 2; i++) p = (p * 2) % Q;
        return Q_WIDTH'(p + addr % 2);
    endfunction

    assign psi_value = romFn(int'(psi_addr));

    ntt_twiddle_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .psi_addr  (psi_addr),
        .psi_value (psi_value),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .tw_value  (tw_value),
        .tw_idx_a  (tw_idx_a),
        .tw_idx_b  (tw_idx_b),
        .tw_stage  (tw_stage),
        .tw_last   (tw_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nTests++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Reference schedule built from the textbook divide/modulo form.
    task automatic pushRun();
        entry_t e;
        int t, g, k, addr;
        for (int s = 0; s < LOGN; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                t       = N >> (s + 1);
                g       = j / t;
                k       = j % t;
                e.a     = 2 * g * t + k;
                e.b     = e.a + t;
                addr    = s * (N / 2) + j;
                e.stage = s;
                e.last  = (s == LOGN - 1 && j == N / 2 - 1) ? 1 : 0;
                e.value = int'(romFn(addr));
                expQ.push_back(e);
            end
        end
    endtask

    // Monitor: done bookkeeping, then scoreboard pop for the pending transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            pendingDone = 1'b0;
        end else begin
            if (done) doneSeen++;
            if (pendingDone) begin
                checkOutput("done_pulse", int'(done), 1);
                checkOutput("busy_after_done", int'(busy), 0);
                pendingDone = 1'b0;
            end else begin
                checkOutput("no_stray_done", int'(done), 0);
            end
            if (tw_valid && tw_ready && !abort) begin
                if (expQ.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("[TB] FAIL unexpected_entry: got a=%0d b=%0d stage=%0d, required no entry",
                             tw_idx_a, tw_idx_b, tw_stage);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("entry_a", int'(tw_idx_a), monEntry.a);
                    checkOutput("entry_b", int'(tw_idx_b), monEntry.b);
                    checkOutput("entry_stage", int'(tw_stage), monEntry.stage);
                    checkOutput("entry_last", int'(tw_last), monEntry.last);
                    checkOutput("entry_value", int'(tw_value), monEntry.value);
                    if (runXfer == 0) begin
                        checkOutput("x0_a", int'(tw_idx_a), 0);
                        checkOutput("x0_b", int'(tw_idx_b), 16);
                    end
                    if (runXfer == 15) begin
                        checkOutput("x15_a", int'(tw_idx_a), 15);
                        checkOutput("x15_b", int'(tw_idx_b), 31);
                    end
                    if (runXfer == 24) begin
                        checkOutput("x24_a", int'(tw_idx_a), 16);
                        checkOutput("x24_b", int'(tw_idx_b), 24);
                        checkOutput("x24_value", int'(tw_value), 4096);
                    end
                    if (runXfer == 69) begin
                        checkOutput("x69_a", int'(tw_idx_a), 10);
                        checkOutput("x69_b", int'(tw_idx_b), 11);
                    end
                    if (runXfer == 79) begin
                        checkOutput("x79_a", int'(tw_idx_a), 30);
                        checkOutput("x79_b", int'(tw_idx_b), 31);
                        checkOutput("x79_last", int'(tw_last), 1);
                    end
                    if (monEntry.last != 0) pendingDone = 1'b1;
                    runXfer++;
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (randReady) tw_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input bit doStart, input bit doAbort);
        start = doStart;
        abort = doAbort;
        stepCycle();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic startRun();
        pushRun();
        runXfer = 0;
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < 1000) begin
            stepCycle();
            cycles++;
        end
        checkOutput("done_within_bound", int'(done), 1);
    endtask

    task automatic checkRunComplete();
        checkOutput("run_xfers", runXfer, 80);
        checkOutput("queue_drained", expQ.size(), 0);
    endtask

    initial begin
        int cycles;
        int doneBefore;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", int'(tw_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_addr", int'(psi_addr), 0);
        checkOutput("rst_value", int'(tw_value), 0);
        checkOutput("rst_idx_a", int'(tw_idx_a), 0);
        checkOutput("rst_idx_b", int'(tw_idx_b), 0);
        checkOutput("rst_stage", int'(tw_stage), 0);
        checkOutput("rst_last", int'(tw_last), 0);
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] Test 1: full schedule with tw_ready held high");
        doneBefore = doneSeen;
        startRun();
        checkOutput("t1_busy", int'(busy), 1);
        checkOutput("t1_no_valid_yet", int'(tw_valid), 0);
        checkOutput("t1_first_addr", int'(psi_addr), 0);
        stepCycle();
        checkOutput("t1_first_valid", int'(tw_valid), 1);
        repeat (23) stepCycle();
        checkOutput("t1_addr24", int'(psi_addr), 24);
        waitDone(cycles);
        checkOutput("t1_cycles_to_done", cycles + 24, 81);
        checkOutput("t1_busy_at_done", int'(busy), 0);
        checkRunComplete();
        stepCycle();
        checkOutput("t1_done_one_cycle", int'(done), 0);
        checkOutput("t1_done_count", doneSeen - doneBefore, 1);

        $display("[TB] Test 2: three-cycle stall at transfer 10");
        startRun();
        repeat (11) stepCycle();
        tw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_stall_valid", int'(tw_valid), 1);
            checkOutput("t2_stall_a", int'(tw_idx_a), 10);
            checkOutput("t2_stall_b", int'(tw_idx_b), 26);
            checkOutput("t2_stall_value", int'(tw_value), 32);
            checkOutput("t2_stall_addr", int'(psi_addr), 11);
            if (i < 3) stepCycle();
        end
        tw_ready = 1'b1;
        waitDone(cycles);
        checkRunComplete();
        stepCycle();

        $display("[TB] Test 3: start pulsed mid-run and on the done cycle");
        doneBefore = doneSeen;
        startRun();
        repeat (40) stepCycle();
        applyStimulus(1'b1, 1'b0);
        waitDone(cycles);
        checkRunComplete();
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_start_on_done_busy", int'(busy), 0);
        repeat (3) stepCycle();
        checkOutput("t3_idle_valid", int'(tw_valid), 0);
        checkOutput("t3_idle_busy", int'(busy), 0);
        checkOutput("t3_done_count", doneSeen - doneBefore, 1);

        $display("[TB] Test 4: abort at transfer 50, then restart");
        doneBefore = doneSeen;
        startRun();
        repeat (51) stepCycle();
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_abort_valid", int'(tw_valid), 0);
        checkOutput("t4_abort_busy", int'(busy), 0);
        checkOutput("t4_abort_addr", int'(psi_addr), 0);
        checkOutput("t4_abort_xfers", runXfer, 50);
        expQ.delete();
        repeat (2) stepCycle();
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_idle_abort_busy", int'(busy), 0);
        checkOutput("t4_no_done", doneSeen - doneBefore, 0);
        startRun();
        checkOutput("t4_restart_addr", int'(psi_addr), 0);
        stepCycle();
        checkOutput("t4_restart_a", int'(tw_idx_a), 0);
        checkOutput("t4_restart_valid", int'(tw_valid), 1);
        waitDone(cycles);
        checkRunComplete();
        stepCycle();

        $display("[TB] Test 5: asynchronous reset mid-cycle at transfer 30");
        startRun();
        repeat (31) stepCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", int'(tw_valid), 0);
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_addr", int'(psi_addr), 0);
        checkOutput("t5_rst_value", int'(tw_value), 0);
        checkOutput("t5_rst_idx_a", int'(tw_idx_a), 0);
        checkOutput("t5_rst_idx_b", int'(tw_idx_b), 0);
        checkOutput("t5_rst_stage", int'(tw_stage), 0);
        expQ.delete();
        stepCycle();
        rst_n = 1'b1;
        repeat (3) stepCycle();
        checkOutput("t5_idle_busy", int'(busy), 0);
        checkOutput("t5_idle_valid", int'(tw_valid), 0);
        checkOutput("t5_idle_addr", int'(psi_addr), 0);

        $display("[TB] Test 6: three runs with random tw_ready");
        doneBefore = doneSeen;
        randReady = 1'b1;
        for (int r = 0; r < 3; r++) begin
            startRun();
            waitDone(cycles);
            checkRunComplete();
            stepCycle();
        end
        randReady = 1'b0;
        tw_ready = 1'b1;
        stepCycle();
        checkOutput("t6_done_count", doneSeen - doneBefore, 3);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/ntt_twiddle_sequencer.md
Name: ntt_twiddle_sequencer

Overview:
Address-side initiator for the combinational twiddle (psi) ROM used by the NTT datapath.
- Walks every stage s and butterfly j of an N-point Cooley-Tukey forward NTT.
- Drives the ROM address and registers the returned twiddle.
- Presents {twiddle, operand indices, stage} to the butterfly unit over a valid/ready stream at up to one butterfly per cycle.

Parameters:
N, 32, transform length (power of two, >= 4)
LOGN, 5, log2(N) = number of stages
Q_WIDTH, 17, twiddle/coefficient width (q = 65537)
ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= LOGN*N/2
IDX_W, 5, coefficient index width = LOGN

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle request to run a full transform schedule
abort  in  1  synchronous cancel of a running schedule
psi_addr  out  ADDR_W  address to the twiddle ROM (combinational from counters)
psi_value  in  Q_WIDTH  ROM data for psi_addr, same cycle
tw_valid  out  1  output entry valid
tw_ready  in  1  butterfly unit accepts entry
tw_value  out  Q_WIDTH  registered twiddle
tw_idx_a  out  IDX_W  upper butterfly operand index
tw_idx_b  out  IDX_W  lower butterfly operand index
tw_stage  out  3  stage of entry
tw_last  out  1  entry is the final butterfly of the schedule
busy  out  1  schedule in progress
done  out  1  one-cycle pulse when the last entry is consumed

Behaviour:
- Reset (rst_n low, any time, including mid-run):
  - State IDLE; counters s = 0 and j = 0.
  - tw_valid, tw_value, tw_idx_a, tw_idx_b, tw_stage, tw_last, busy and done all 0.
  - psi_addr = 0.
- Index and address math (combinational from s, j):
  - t = N >> (s+1); g = j / t; k = j mod t.
  - idx_a = 2*g*t + k; idx_b = idx_a + t.
  - psi_addr = s*(N/2) + j.
  - All shifts and divides reduce to bit slicing because t is a power of two.
- States:
  - IDLE: busy = 0. On start = 1 go to RUN, clear s and j, set busy = 1.
  - RUN: load is enabled when the output register is empty or being consumed (!tw_valid | tw_ready).
    - On load: capture psi_value and indices, tw_valid = 1, tw_last = (s == LOGN-1 && j == N/2-1).
    - Then advance j; when j wraps from N/2-1 to 0, s increments.
    - After loading the last entry go to DRAIN.
  - DRAIN: no loads. When tw_valid & tw_ready: tw_valid = 0, done = 1 for exactly one cycle, busy = 0, go to IDLE.
- Latency and throughput:
  - start sampled at edge E0; first entry is valid after E1.
  - With tw_ready held at 1, one entry transfers per cycle, for N/2*LOGN = 80 transfers.
  - done is high in the cycle after the edge that transferred the entry with tw_last = 1.
- Backpressure: while tw_valid = 1 and tw_ready = 0, all tw_* outputs hold and the counters hold.
- start while busy: ignored.
- start in the same cycle as done: ignored; a new run needs start in IDLE.
- abort = 1 while busy:
  - Next edge: IDLE, tw_valid = 0, counters cleared, no done pulse.
  - abort has priority over load and over consumption.
- abort while IDLE: no effect.
- tw_idx_a/b never exceed N-1, and psi_addr never exceeds LOGN*N/2-1.

Decomposition:
- Shared package ntt_pkg: N, LOGN, Q (65537), Q_WIDTH, ADDR_W, IDX_W, and the state enum {IDLE, RUN, DRAIN}.
- One sub-module, ntt_index_gen: purely combinational (s, j) -> (idx_a, idx_b, psi_addr, last).
  - The top level holds the FSM, counters and output register.
  - The ROM sits outside the block.

Test Plan:
1. Reset then start with tw_ready = 1 and the ROM connected -> 80 transfers on consecutive cycles.
   - First: stage 0, a = 0, b = 16, addr 0.
   - Transfer 15: a = 15, b = 31.
   - Transfer 24 (stage 1, j = 8): a = 16, b = 24, addr 24, tw_value 4096.
   - Transfer 69 (stage 4, j = 5): a = 10, b = 11.
   - Final: a = 30, b = 31, tw_last = 1; then done = 1 for one cycle and busy = 0.
2. tw_ready low for 3 cycles at transfer 10 -> tw_* outputs stable across the stall; sequence resumes with no skipped or duplicated entries; 80 transfers total.
3. start pulsed again at transfer 40 -> ignored; schedule completes unchanged with a single done pulse.
4. abort at transfer 50 -> tw_valid = 0 and busy = 0 after one edge, no done; a fresh start then begins again at addr 0.
5. rst_n low asynchronously mid-cycle at transfer 30 -> all outputs 0 immediately, without waiting for a clock edge; after release the block stays in IDLE until start.
6. Random tw_ready (50%) over 3 back-to-back runs -> each run delivers exactly 80 entries matching a reference index/address model, with done count = 3.
